writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 24 ++
 rtl/writeback_stage_load_aligner.sv | 30 +++
 rtl/writeback_stage.sv | 127 ++++++++++++
 tb/tb_writeback_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared Lucid64 encodings for the writeback stage: destination sources,
// load widths and writeback FSM states.
package writeback_stage_pkg;

  localparam logic [2:0] RD_SRC_1H_ALU = 3'b001;
  localparam logic [2:0] RD_SRC_1H_MEM = 3'b010;
  localparam logic [2:0] RD_SRC_1H_PC  = 3'b100;

  localparam logic [3:0] MEM_WIDTH_1H_B = 4'b0001;
  localparam logic [3:0] MEM_WIDTH_1H_H = 4'b0010;
  localparam logic [3:0] MEM_WIDTH_1H_W = 4'b0100;
  localparam logic [3:0] MEM_WIDTH_1H_D = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } wb_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Load data alignment: selects the addressed lane of an 8-byte line and
// sign- or zero-extends it to 64 bits.
module load_aligner
  import writeback_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  byte_addr,
  input  logic [3:0]  width_1h,
  input  logic        sign,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_addr, 3'b000};
    data    = '0;
    case (width_1h)
      MEM_WIDTH_1H_B: data = sign ? {{56{shifted[7]}}, shifted[7:0]}
                                  : {56'd0, shifted[7:0]};
      MEM_WIDTH_1H_H: data = sign ? {{48{shifted[15]}}, shifted[15:0]}
                                  : {48'd0, shifted[15:0]};
      MEM_WIDTH_1H_W: data = sign ? {{32{shifted[31]}}, shifted[31:0]}
                                  : {32'd0, shifted[31:0]};
      MEM_WIDTH_1H_D: data = shifted;
      default:        data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits ALU/PC results or aligned load data to the register
// file, buffering late load data across stalls. LUCID64_INSTRET_EN adds instret.
//
// state | meaning
// IDLE  | no load outstanding, or load data arriving this cycle
// WAIT  | load present, memory response not yet seen
// HOLD  | load data captured in buffer, waiting for stall_i to drop
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic [63:0] rd_data_i,
  input  logic [4:0]  rd_idx_i,
  input  logic        rd_wr_en_i,
  input  logic [2:0]  rd_wr_src_1h_i,
  input  logic [3:0]  mem_width_1h_i,
  input  logic        mem_sign_i,
  input  logic [2:0]  byte_addr_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [63:0] rf_wr_data_o,
  output logic        retire_o,
  output logic        wb_stall_o,
  output logic [63:0] instret_o
);

  wb_state_e   state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic        is_load;
  logic        data_ready;
  logic        commit;
  logic [63:0] line_data;
  logic [63:0] load_data;

  assign is_load = valid_i && (rd_wr_src_1h_i == RD_SRC_1H_MEM);

  always_comb begin
    data_ready = 1'b1;
    if (is_load && (state_q != HOLD)) begin
      data_ready = dmem_rvalid_i;
    end
  end

  assign commit = ~rst_i & valid_i & data_ready & ~stall_i;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE, WAIT: begin
        // rvalid without a load in flight is not ours; leave everything alone
        if (is_load) begin
          if (!dmem_rvalid_i) begin
            state_d = WAIT;
          end else if (stall_i) begin
            state_d = HOLD;
            buf_d   = dmem_rdata_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign line_data = (state_q == HOLD) ? buf_q : dmem_rdata_i;

  load_aligner u_load_aligner (
    .rdata     (line_data),
    .byte_addr (byte_addr_i),
    .width_1h  (mem_width_1h_i),
    .sign      (mem_sign_i),
    .data      (load_data)
  );

  // A malformed source still retires but never writes the register file
  assign rf_wr_en_o   = commit & rd_wr_en_i & (rd_idx_i != 5'd0) & is_onehot3(rd_wr_src_1h_i);
  assign rf_wr_idx_o  = rd_idx_i;
  assign rf_wr_data_o = (rd_wr_src_1h_i == RD_SRC_1H_MEM) ? load_data : rd_data_i;
  assign retire_o     = commit;
  assign wb_stall_o   = ~rst_i & is_load & ~data_ready;

`ifdef LUCID64_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (commit) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed scenarios then random traffic,
// checked against a behavioural load/commit model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] rd_data_i = '0;
  logic [4:0]  rd_idx_i = '0;
  logic        rd_wr_en_i = 1'b0;
  logic [2:0]  rd_wr_src_1h_i = 3'b001;
  logic [3:0]  mem_width_1h_i = 4'b0001;
  logic        mem_sign_i = 1'b0;
  logic [2:0]  byte_addr_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [63:0] dmem_rdata_i = '0;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [63:0] rf_wr_data_o;
  logic        retire_o;
  logic        wb_stall_o;
  logic [63:0] instret_o;

  always #5 clk_i = ~clk_i;

  writeback_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .valid_i        (valid_i),
    .rd_data_i      (rd_data_i),
    .rd_idx_i       (rd_idx_i),
    .rd_wr_en_i     (rd_wr_en_i),
    .rd_wr_src_1h_i (rd_wr_src_1h_i),
    .mem_width_1h_i (mem_width_1h_i),
    .mem_sign_i     (mem_sign_i),
    .byte_addr_i    (byte_addr_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_idx_o    (rf_wr_idx_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .retire_o       (retire_o),
    .wb_stall_o     (wb_stall_o),
    .instret_o      (instret_o)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  idx;
    logic [63:0] data;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          stall_cnt = 0;
  logic [63:0] retired = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] exp_instret(input logic [63:0] n);
`ifdef LUCID64_INSTRET_EN
    return n;
`else
    return 64'd0;
`endif
  endfunction

  // Reference alignment: plain shift/mask arithmetic on byte counts
  function automatic logic [63:0] ref_load(input logic [63:0] line, input int addr,
                                           input int nbytes, input bit sgn);
    logic [63:0] v, mask;
    v = line >> (addr * 8);
    if (nbytes < 8) begin
      mask = (64'd1 << (nbytes * 8)) - 64'd1;
      v = v & mask;
      if (sgn && v[nbytes*8-1]) v = v | ~mask;
    end
    return v;
  endfunction

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_i) begin
      chk("rst_retire", {63'd0, retire_o}, 64'd0);
      chk("rst_wr_en", {63'd0, rf_wr_en_o}, 64'd0);
      chk("rst_wb_stall", {63'd0, wb_stall_o}, 64'd0);
      stall_cnt = 0;
      retired   = '0;
    end else begin
      if (wb_stall_o) stall_cnt++;
      if (rf_wr_en_o) chk("wr_without_retire", {63'd0, retire_o}, 64'd1);
      if (retire_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_retire", {63'd0, retire_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_en", {63'd0, rf_wr_en_o}, {63'd0, e.wr_en});
          if (e.wr_en) begin
            chk("wr_idx", {59'd0, rf_wr_idx_o}, {59'd0, e.idx});
            chk("wr_data", rf_wr_data_o, e.data);
          end
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("instret", instret_o, exp_instret(retired));
        end
        stall_cnt = 0;
        retired   = retired + 64'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // d: cycles before rvalid (loads); s: stall cycles (at/after rvalid for loads)
  task automatic issue(input logic [2:0] src, input logic wen, input logic [4:0] idx,
                       input logic [63:0] rdd, input logic [3:0] w1h, input logic sgn,
                       input logic [2:0] addr, input logic [63:0] line,
                       input int d, input int s);
    exp_t e;
    int   nb;
    bit   ld;
    ld = (src == 3'b010);
    nb = (w1h == 4'b0001) ? 1 : (w1h == 4'b0010) ? 2 : (w1h == 4'b0100) ? 4 : 8;
    e.wr_en  = wen && (idx != 0) && ($countones(src) == 1);
    e.idx    = idx;
    e.data   = ld ? ref_load(line, int'(addr), nb, sgn) : rdd;
    e.stalls = ld ? d : 0;
    exp_q.push_back(e);

    valid_i = 1'b1; rd_wr_src_1h_i = src; rd_wr_en_i = wen; rd_idx_i = idx;
    rd_data_i = rdd; mem_width_1h_i = w1h; mem_sign_i = sgn; byte_addr_i = addr;
    if (ld) begin
      for (int i = 0; i < d; i++) begin
        dmem_rvalid_i = 1'b0; dmem_rdata_i = {$urandom, $urandom};
        stall_i = 1'($urandom_range(0, 1)); tick();
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = line; stall_i = (s > 0); tick();
      for (int i = 1; i < s; i++) begin
        dmem_rvalid_i = 1'b0; dmem_rdata_i = {$urandom, $urandom}; stall_i = 1'b1; tick();
      end
      if (s > 0) begin
        dmem_rvalid_i = 1'b0; dmem_rdata_i = {$urandom, $urandom}; stall_i = 1'b0; tick();
      end
    end else begin
      for (int i = 0; i < s; i++) begin
        stall_i = 1'b1; dmem_rvalid_i = 1'($urandom_range(0, 1)); tick();
      end
      stall_i = 1'b0; dmem_rvalid_i = 1'($urandom_range(0, 1)); tick();
    end
    valid_i = 1'b0; stall_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("commit_seen", exp_q.size(), 64'd0);
    exp_q.delete();
  endtask

  task automatic reset_in_hold();
    valid_i = 1'b1; rd_wr_src_1h_i = 3'b010; rd_wr_en_i = 1'b1; rd_idx_i = 5'd12;
    mem_width_1h_i = 4'b1000; byte_addr_i = 3'd0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_0000_1111; stall_i = 1'b1; tick();
    dmem_rvalid_i = 1'b0; tick();
    // reset collides with both an rvalid and a would-be commit from the buffer
    rst_i = 1'b1; dmem_rvalid_i = 1'b1; stall_i = 1'b0; tick();
    rst_i = 1'b0; valid_i = 1'b0; dmem_rvalid_i = 1'b0; tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] src;
    logic [3:0] w1h;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    issue(3'b001, 1'b1, 5'd5, 64'h1234, 4'b0001, 1'b0, 3'd0, 64'd0, 0, 0);
    issue(3'b010, 1'b1, 5'd7, 64'h5555, 4'b0001, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 2, 0);
    issue(3'b010, 1'b1, 5'd9, 64'h0, 4'b0010, 1'b0, 3'd6, 64'hABCD_0000_0000_0000, 0, 3);
    issue(3'b001, 1'b1, 5'd0, 64'h77, 4'b0001, 1'b0, 3'd0, 64'd0, 0, 1);
    chk("instret_after_rd0", instret_o, exp_instret(64'd4));
    issue(3'b011, 1'b1, 5'd4, 64'h99, 4'b0001, 1'b0, 3'd0, 64'd0, 0, 0);
    issue(3'b000, 1'b1, 5'd4, 64'h99, 4'b0001, 1'b0, 3'd0, 64'd0, 0, 0);
    issue(3'b100, 1'b0, 5'd8, 64'h42, 4'b0001, 1'b0, 3'd0, 64'd0, 0, 2);

    reset_in_hold();
    chk("instret_after_reset", instret_o, 64'd0);
    // a stuck HOLD would commit this load with no stall cycle
    issue(3'b010, 1'b1, 5'd3, 64'h0, 4'b1000, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 0);

    for (int i = 0; i < 4; i++) begin
      dmem_rvalid_i = 1'b1; dmem_rdata_i = {$urandom, $urandom}; stall_i = 1'($urandom_range(0, 1));
      tick();
    end
    dmem_rvalid_i = 1'b0; stall_i = 1'b0;
    issue(3'b010, 1'b1, 5'd6, 64'h0, 4'b0100, 1'b1, 3'd4, 64'hF000_0001_1234_5678, 1, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: src = 3'b001;
        3:       src = 3'b100;
        4:       src = 3'($urandom_range(0, 7));
        default: src = 3'b010;
      endcase
      w1h = 4'b0001 << $urandom_range(0, 3);
      issue(src, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            w1h, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        dmem_rvalid_i = 1'($urandom_range(0, 1)); dmem_rdata_i = {$urandom, $urandom};
        tick();
      end
      dmem_rvalid_i = 1'b0;
    end

    repeat (2) tick();
    chk("instret_final", instret_o, exp_instret(retired));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
